mac_tx_scheduler: RTL and testbench

// - Multi-queue TX scheduler ahead of the MAC TX AXI-stream port. Shares one 128-bit MAC TX path between NUM_Q queue streams.
// - Uses frame-atomic weighted round-robin (WRR). Blocks new frame starts on pause, link-down or closed gates.
// - Enforces a minimum idle gap between frames on the MAC side.

---
 rtl/mac_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mac_tx_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_scheduler.sv
// Frame-atomic weighted round-robin scheduler merging NUM_Q AXI-stream TX queues onto one MAC TX port.
// Optional 802.1Qbv gating is enabled by defining ETH_TX_QBV_EN (adds the gate_open input).
module mac_tx_scheduler #(
  parameter int NUM_Q      = 4,
  parameter int DATA_W     = 128,
  parameter int IPG_CYCLES = 2
) (
  input  logic                       clk_sys,
  input  logic                       rst_sys,
  input  logic [NUM_Q-1:0]           q_tvalid,
  input  logic [NUM_Q-1:0]           q_tlast,
  input  logic [NUM_Q*DATA_W-1:0]    q_tdata,
  output logic [NUM_Q-1:0]           q_tready,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  output logic [DATA_W-1:0]          m_tdata,
  input  logic                       m_tready,
  input  logic [NUM_Q*4-1:0]         cfg_weight,
  input  logic                       link_status,
  input  logic                       pause_active,
`ifdef ETH_TX_QBV_EN
  input  logic [NUM_Q-1:0]           gate_open,
`endif
  output logic [$clog2(NUM_Q)-1:0]   grant_q,
  output logic                       frame_start,
  output logic                       frame_done
);

  // state | meaning
  // IDLE  | waiting for link up, no pause and an eligible queue
  // ARB   | one cycle: pick first eligible queue from rr_ptr, latch grant_q
  // XFER  | pass-through of the granted queue until its tlast beat is accepted
  // GAP   | forced idle of IPG_CYCLES cycles on the MAC side

  localparam int QW = $clog2(NUM_Q);
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_GAP} state_t;

  state_t            state;
  logic [QW-1:0]     rr_ptr;
  logic [3:0]        credit [NUM_Q];
  logic              first_beat;
  logic              chk_pending;
  logic [GW-1:0]     gap_cnt;

  logic [DATA_W-1:0] q_data   [NUM_Q];
  logic [3:0]        q_weight [NUM_Q];
  logic [NUM_Q-1:0]  gate_eff;
  logic [NUM_Q-1:0]  elig;
  logic              may_start;
  logic [QW-1:0]     pick_q;
  logic              pick_found;
  logic [QW:0]       pick_sum;
  logic              in_xfer;
  logic              accept;
  logic [3:0]        credit_inc;
  logic [QW-1:0]     next_g;

`ifdef ETH_TX_QBV_EN
  assign gate_eff = gate_open;
`else
  assign gate_eff = '1;
`endif

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      q_data[i]   = q_tdata[i*DATA_W +: DATA_W];
      q_weight[i] = cfg_weight[i*4 +: 4];
      elig[i]     = q_tvalid[i] && (cfg_weight[i*4 +: 4] != 4'd0) && gate_eff[i];
    end
  end

  assign may_start = link_status && !pause_active;

  // Scan from the farthest candidate down so the nearest eligible queue wins.
  always_comb begin
    pick_found = 1'b0;
    pick_q     = '0;
    pick_sum   = '0;
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      pick_sum = {1'b0, rr_ptr} + (QW+1)'(k);
      if (pick_sum >= (QW+1)'(NUM_Q))
        pick_sum = pick_sum - (QW+1)'(NUM_Q);
      if (elig[pick_sum[QW-1:0]]) begin
        pick_found = 1'b1;
        pick_q     = pick_sum[QW-1:0];
      end
    end
  end

  assign in_xfer = (state == S_XFER);

  always_comb begin
    for (int i = 0; i < NUM_Q; i++)
      q_tready[i] = in_xfer && (grant_q == QW'(i)) && m_tready;
  end

  assign m_tvalid    = in_xfer ? q_tvalid[grant_q] : 1'b0;
  assign m_tlast     = in_xfer ? q_tlast[grant_q]  : 1'b0;
  assign m_tdata     = in_xfer ? q_data[grant_q]   : '0;
  assign accept      = m_tvalid && m_tready;
  assign frame_start = accept && first_beat;
  assign frame_done  = accept && m_tlast;

  assign credit_inc = (credit[grant_q] == 4'hF) ? 4'hF : credit[grant_q] + 4'd1;
  assign next_g     = (grant_q == QW'(NUM_Q - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_q     <= '0;
      first_beat  <= 1'b0;
      chk_pending <= 1'b0;
      gap_cnt     <= '0;
      for (int i = 0; i < NUM_Q; i++)
        credit[i] <= '0;
    end else begin
      chk_pending <= 1'b0;
      // A queue that keeps its turn but has nothing queued right after tlast yields.
      if (chk_pending && !q_tvalid[grant_q]) begin
        credit[grant_q] <= '0;
        rr_ptr          <= next_g;
      end
      case (state)
        S_IDLE: begin
          if (may_start && (|elig))
            state <= S_ARB;
        end
        S_ARB: begin
          if (may_start && pick_found) begin
            grant_q    <= pick_q;
            first_beat <= 1'b1;
            state      <= S_XFER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_XFER: begin
          if (accept) begin
            first_beat <= 1'b0;
            if (m_tlast) begin
              if (credit_inc >= q_weight[grant_q]) begin
                credit[grant_q] <= '0;
                rr_ptr          <= next_g;
              end else begin
                credit[grant_q] <= credit_inc;
                rr_ptr          <= grant_q;
                chk_pending     <= 1'b1;
              end
              gap_cnt <= GAP_LOAD;
              state   <= (IPG_CYCLES > 0) ? S_GAP : S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0)
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Directed bench for mac_tx_scheduler: reset, WRR order and gap, pause, disabled queue,
// backpressure, mid-frame reset and (with ETH_TX_QBV_EN) gating.
module tb_mac_tx_scheduler;

  localparam int NQ = 4;
  localparam int DW = 128;

  logic              clk_sys = 1'b0;
  logic              rst_sys;
  logic [NQ-1:0]     q_tvalid;
  logic [NQ-1:0]     q_tlast;
  logic [NQ*DW-1:0]  q_tdata;
  logic [NQ-1:0]     q_tready;
  logic              m_tvalid;
  logic              m_tlast;
  logic [DW-1:0]     m_tdata;
  logic              m_tready;
  logic [NQ*4-1:0]   cfg_weight;
  logic              link_status;
  logic              pause_active;
  logic [1:0]        grant_q;
  logic              frame_start;
  logic              frame_done;
`ifdef ETH_TX_QBV_EN
  logic [NQ-1:0]     gate_open;
`endif

  logic [DW-1:0] qd [NQ];

  always #5 clk_sys = ~clk_sys;

  always_comb begin
    for (int i = 0; i < NQ; i++) q_tdata[i*DW +: DW] = qd[i];
  end

  mac_tx_scheduler #(.NUM_Q(NQ), .DATA_W(DW), .IPG_CYCLES(2)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .q_tvalid(q_tvalid), .q_tlast(q_tlast), .q_tdata(q_tdata), .q_tready(q_tready),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
    .cfg_weight(cfg_weight), .link_status(link_status), .pause_active(pause_active),
`ifdef ETH_TX_QBV_EN
    .gate_open(gate_open),
`endif
    .grant_q(grant_q), .frame_start(frame_start), .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int            cyc = 0;
  int            st_q[$];
  int            st_cyc[$];
  int            done_cyc[$];
  logic [DW-1:0] acc_data[$];
  bit            saw_rdy1 = 0;
  int            stall_bad = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk_sys) begin
    if (!rst_sys) begin
      if (frame_start) begin st_q.push_back(int'(grant_q)); st_cyc.push_back(cyc); end
      if (frame_done) done_cyc.push_back(cyc);
      if (m_tvalid && m_tready) acc_data.push_back(m_tdata);
      if (q_tready[1]) saw_rdy1 = 1;
      if (stall_prev && (!m_tvalid || m_tdata !== stall_data)) stall_bad++;
      stall_prev = m_tvalid && !m_tready;
      stall_data = m_tdata;
    end
    cyc++;
  end

  task automatic clear_log();
    st_q.delete(); st_cyc.delete(); done_cyc.delete(); acc_data.delete();
  endtask

  task automatic wait_done(input int n, input string tag);
    int g = 0;
    while (done_cyc.size() < n && g < 500) begin @(posedge clk_sys); g++; end
    chk(tag, done_cyc.size() >= n, 1);
  endtask

  task automatic send_frame(input int q, input int n, input logic [DW-1:0] base, output bit ok);
    int beat = 0;
    int guard = 0;
    bit rdy;
    qd[q] = base; q_tlast[q] = (n == 1); q_tvalid[q] = 1'b1;
    while (beat < n && guard < 400) begin
      @(negedge clk_sys); rdy = q_tready[q];
      @(posedge clk_sys); #1; guard++;
      if (rdy) begin
        beat++;
        if (beat < n) begin qd[q] = base + DW'(beat); q_tlast[q] = (beat == n - 1); end
      end
    end
    q_tvalid[q] = 1'b0; q_tlast[q] = 1'b0;
    ok = (beat == n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int exp_wrr[6] = '{0, 0, 1, 0, 0, 1};
  int exp_w0[6]  = '{0, 2, 0, 2, 0, 2};
  bit ok1, ok2;
  bit tx_busy;
  int n0;

  initial begin
    rst_sys = 1'b1; q_tvalid = '0; q_tlast = '0; m_tready = 1'b1;
    cfg_weight = '0; link_status = 1'b1; pause_active = 1'b0;
    for (int i = 0; i < NQ; i++) qd[i] = '0;
`ifdef ETH_TX_QBV_EN
    gate_open = '1;
`endif
    repeat (3) @(posedge clk_sys);
    #1 rst_sys = 1'b0;
    @(negedge clk_sys);
    chk("rst_q_tready", q_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_grant", grant_q, 0);
    chk("rst_fstart", frame_start, 0);
    chk("rst_fdone", frame_done, 0);

    // WRR: weights 2/1, single-beat frames on Q0/Q1.
    @(posedge clk_sys); #1;
    clear_log();
    for (int i = 0; i < NQ; i++) qd[i] = DW'(32'h1000 + i);
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd2};
    q_tlast = 4'b0011; q_tvalid = 4'b0011;
    wait_done(6, "wrr_timeout");
    @(posedge clk_sys); #1 q_tvalid = '0; q_tlast = '0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wrr_grant%0d", k), st_q[k], exp_wrr[k]);
      chk($sformatf("wrr_data%0d", k), acc_data[k], DW'(32'h1000 + exp_wrr[k]));
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("wrr_gap%0d", k), st_cyc[k+1] - done_cyc[k] - 1, 4);
    repeat (8) @(posedge clk_sys); #1;

    // Pause raised during a 4-beat Q2 frame.
    clear_log();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    fork
      send_frame(2, 4, DW'(32'h2000), ok1);
      begin
        int g = 0;
        while (st_q.size() < 1 && g < 200) begin @(posedge clk_sys); g++; end
        #1 pause_active = 1'b1;
      end
    join
    chk("pause_frame_ok", ok1, 1);
    chk("pause_beats", acc_data.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("pause_data%0d", k), acc_data[k], DW'(32'h2000 + k));
    chk("pause_done_cnt", done_cyc.size(), 1);
    fork
      send_frame(2, 1, DW'(32'h2100), ok2);
      begin
        repeat (20) @(posedge clk_sys);
        chk("pause_hold", st_q.size(), 1);
        #1 pause_active = 1'b0;
      end
    join
    chk("pause_resume_ok", ok2, 1);
    chk("pause_resume_cnt", st_q.size(), 2);
    chk("pause_resume_grant", st_q[1], 2);
    repeat (8) @(posedge clk_sys); #1;

    // Queue 1 disabled by weight 0.
    clear_log();
    saw_rdy1 = 0;
    for (int i = 0; i < NQ; i++) qd[i] = DW'(32'h1000 + i);
    cfg_weight = {4'd1, 4'd1, 4'd0, 4'd1};
    q_tlast = 4'b0111; q_tvalid = 4'b0111;
    wait_done(6, "w0_timeout");
    @(posedge clk_sys); #1 q_tvalid = '0; q_tlast = '0;
    for (int k = 0; k < 6; k++) chk($sformatf("w0_grant%0d", k), st_q[k], exp_w0[k]);
    chk("w0_rdy1", saw_rdy1, 0);
    repeat (8) @(posedge clk_sys); #1;

    // Backpressure 1010 during a 3-beat Q3 frame.
    clear_log();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    stall_bad = 0;
    tx_busy = 1'b1;
    fork
      begin send_frame(3, 3, DW'(32'h3000), ok1); tx_busy = 1'b0; end
      while (tx_busy) begin @(posedge clk_sys); #1 m_tready = ~m_tready; end
    join
    m_tready = 1'b1;
    repeat (6) @(posedge clk_sys); #1;
    chk("bp_frame_ok", ok1, 1);
    chk("bp_beats", acc_data.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("bp_data%0d", k), acc_data[k], DW'(32'h3000 + k));
    chk("bp_done_cnt", done_cyc.size(), 1);
    chk("bp_grant", st_q[0], 3);
    chk("bp_stall_stable", stall_bad, 0);

    // Reset asserted mid-frame on Q1.
    clear_log();
    qd[1] = DW'(32'h4000); q_tlast[1] = 1'b0; q_tvalid[1] = 1'b1;
    begin
      int g = 0;
      while (st_q.size() < 1 && g < 200) begin @(posedge clk_sys); g++; end
    end
    chk("mid_grant", st_q[0], 1);
    #1 rst_sys = 1'b1;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_q_tready", q_tready, 0);
    chk("mid_rst_grant", grant_q, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    q_tvalid = '0;
    repeat (2) @(posedge clk_sys);
    #1 rst_sys = 1'b0;

`ifdef ETH_TX_QBV_EN
    // Gate 2 closed with every queue valid.
    clear_log();
    for (int i = 0; i < NQ; i++) qd[i] = DW'(32'h1000 + i);
    gate_open = 4'b1011;
    q_tlast = 4'b1111; q_tvalid = 4'b1111;
    wait_done(8, "qbv_timeout");
    @(posedge clk_sys); #1 q_tvalid = '0; q_tlast = '0;
    for (int k = 0; k < 8; k++) chk($sformatf("qbv_not2_%0d", k), st_q[k] == 2, 0);
    repeat (8) @(posedge clk_sys); #1;
    clear_log();
    gate_open = 4'b1111;
    fork
      send_frame(0, 3, DW'(32'h5000), ok1);
      begin
        int g = 0;
        while (st_q.size() < 1 && g < 200) begin @(posedge clk_sys); g++; end
        #1 gate_open[0] = 1'b0;
      end
    join
    chk("qbv_close_ok", ok1, 1);
    chk("qbv_close_beats", acc_data.size(), 3);
    chk("qbv_close_done", done_cyc.size(), 1);
    gate_open = 4'b1111;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
